// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl
//
// Memory-stage responder for the pipeline's load/store path. A request from
// the control decode (memRead/memWrite with byteOp and zeroExtendFlag) is
// turned into one (byte) or two (word, big-endian) transactions on a
// byte-wide req/ack SRAM port. The pipeline is held with stall until the
// access completes, then done pulses for one cycle with the extended load
// result on rdata.
//
// Parameters:
//   ADDR_W       byte address width
//   ACK_TIMEOUT  cycles one byte transaction may wait for mem_ack (1..255)
//
// Ports:
//   clk, rst                rising-edge clock, asynchronous active-high reset
//   memRead, memWrite       load / store request (write wins if both are set)
//   byteOp                  1 = byte access, 0 = 16-bit word
//   zeroExtendFlag          byte loads: 1 = zero-extend, 0 = sign-extend
//   addr, wdata             byte address and store data (SB uses wdata[7:0])
//   rdata                   load result, valid while done = 1
//   stall, done, bus_err    pipeline hold, completion pulse, sticky error
//   mem_req, mem_we         SRAM byte transaction request / write enable
//   mem_addr, mem_wdata     SRAM byte address / write byte
//   mem_ack, mem_rdata      SRAM completion / read byte
//
// Optional feature (compile-time macro DMEM_ALIGN_CHECK_EN):
//   When defined, a word access at an odd address is never issued; the block
//   goes straight to DONE, raises bus_err and returns rdata = 0. When not
//   defined, such an access is performed as two byte transactions at A, A+1.
// ---------------------------------------------------------------------------
module data_mem_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic              byteOp,
  input  logic              zeroExtendFlag,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata,
  output logic              stall,
  output logic              done,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BYTE0 = 2'd1,
    BYTE1 = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Latched request, captured read bytes and bookkeeping.
  logic              write_q,  write_d;
  logic              byte_q,   byte_d;
  logic              zext_q,   zext_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic [15:0]       wdata_q,  wdata_d;
  logic [7:0]        hiByte_q, hiByte_d;
  logic [7:0]        loByte_q, loByte_d;
  logic              abort_q,  abort_d;
  logic              err_q,    err_d;
  logic [7:0]        cnt_q,    cnt_d;

  logic accept;
  logic misalign;
  logic inXfer;
  logic timeoutHit;

  assign accept = memRead | memWrite;
  assign inXfer = (state_q == BYTE0) || (state_q == BYTE1);

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = ~byteOp & addr[0];
`else
  assign misalign = 1'b0;
`endif

  // The abort fires on the edge that ends the ACK_TIMEOUT-th waiting cycle,
  // so exactly ACK_TIMEOUT cycles are spent with mem_req high and no ack.
  // An ack arriving on that same cycle still wins.
  assign timeoutHit = inXfer && !mem_ack && (cnt_q == 8'(ACK_TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = misalign ? DONE : BYTE0;
        end
      end
      BYTE0: begin
        if (mem_ack) begin
          state_d = byte_q ? DONE : BYTE1;
        end else if (timeoutHit) begin
          state_d = DONE;
        end
      end
      BYTE1: begin
        if (mem_ack || timeoutHit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // The pipeline advances on this edge, so any request visible now
        // belongs to the access just finished and must not be re-accepted.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: request latch, read-byte capture, ack timer and
  // the sticky error flag.
  always_comb begin
    write_d  = write_q;
    byte_d   = byte_q;
    zext_d   = zext_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    hiByte_d = hiByte_q;
    loByte_d = loByte_q;
    abort_d  = abort_q;
    err_d    = err_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          write_d  = memWrite;
          byte_d   = byteOp;
          zext_d   = zeroExtendFlag;
          addr_d   = addr;
          wdata_d  = wdata;
          hiByte_d = 8'h00;
          loByte_d = 8'h00;
          abort_d  = misalign;
          cnt_d    = 8'd0;
          if (misalign) begin
            err_d = 1'b1;
          end
        end
      end
      BYTE0, BYTE1: begin
        if (mem_ack) begin
          // Clearing on ack also gives BYTE1 a fresh timer on entry.
          cnt_d = 8'd0;
          if (state_q == BYTE0) begin
            hiByte_d = mem_rdata;
          end else begin
            loByte_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (timeoutHit) begin
            abort_d = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      DONE: begin
        cnt_d = 8'd0;
      end
      default: begin
        cnt_d = 8'd0;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_q  <= 1'b0;
      byte_q   <= 1'b0;
      zext_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 16'h0000;
      hiByte_q <= 8'h00;
      loByte_q <= 8'h00;
      abort_q  <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      write_q  <= write_d;
      byte_q   <= byte_d;
      zext_q   <= zext_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      hiByte_q <= hiByte_d;
      loByte_q <= loByte_d;
      abort_q  <= abort_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs. Everything is decoded from registered state, so the async
  // reset drops mem_req in the same cycle it asserts. Bus fields are forced
  // to zero outside a transaction.
  always_comb begin
    stall     = (state_q == IDLE && accept) || inXfer;
    done      = (state_q == DONE);
    bus_err   = err_q;
    mem_req   = inXfer;
    mem_we    = inXfer & write_q;
    mem_addr  = '0;
    mem_wdata = 8'h00;
    rdata     = 16'h0000;

    if (state_q == BYTE0) begin
      mem_addr = addr_q;
      if (write_q) begin
        // Big-endian: a word's first transaction carries the high byte.
        mem_wdata = byte_q ? wdata_q[7:0] : wdata_q[15:8];
      end
    end else if (state_q == BYTE1) begin
      mem_addr = addr_q + ADDR_W'(1);
      if (write_q) begin
        mem_wdata = wdata_q[7:0];
      end
    end

    if (state_q == DONE && !write_q && !abort_q) begin
      if (!byte_q) begin
        rdata = {hiByte_q, loByte_q};
      end else if (zext_q) begin
        rdata = {8'h00, hiByte_q};
      end else begin
        rdata = {{8{hiByte_q[7]}}, hiByte_q};
      end
    end
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Memory-stage responder that executes the load/store requests produced by the control unit's memRead, memWrite, zeroExtendFlag and byte-select decode.
- Converts each 16-bit word or 8-bit byte access into one or two transactions on a byte-wide req/ack data SRAM port.
- Holds the pipeline with a stall until the access completes, then returns extended read data for the memToReg path.

Parameters:
- ADDR_W, 16, byte address width.
- ACK_TIMEOUT, 15, maximum cycles one byte transaction waits for mem_ack before abort; min 1, max 255.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- memRead  in  1  load request from control (LW, LBU).
- memWrite  in  1  store request from control (SW, SB).
- byteOp  in  1  1 = byte access (LBU/SB), 0 = 16-bit word.
- zeroExtendFlag  in  1  byte loads only: 1 = zero-extend, 0 = sign-extend.
- addr  in  ADDR_W  byte address from ALU result.
- wdata  in  16  store data; SB uses wdata[7:0].
- rdata  out  16  load result, valid while done=1.
- stall  out  1  pipeline hold.
- done  out  1  one-cycle completion pulse.
- bus_err  out  1  sticky error flag (timeout, misalignment).
- mem_req  out  1  byte transaction request.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  8  write byte.
- mem_ack  in  1  transaction complete, sampled on the rising edge while mem_req=1.
- mem_rdata  in  8  read byte, valid with mem_ack.

Behaviour:
- Reset (async) values: state=IDLE, rdata=0, done=0, bus_err=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, timeout counter=0. mem_req drops immediately when reset asserts mid-transaction. The partial access is discarded and not replayed.
- States are IDLE, BYTE0, BYTE1, DONE.
- IDLE:
  - A request is accepted when memRead|memWrite is high.
  - If both are high, the write wins.
  - On accept, latch the op, addr, wdata, byteOp and zeroExtendFlag, then go to BYTE0.
- stall is combinational: (state==IDLE && (memRead|memWrite)) || state==BYTE0 || state==BYTE1. It is 0 in DONE.
- Byte order is big-endian.
  - BYTE0 drives mem_addr=A. A store drives wdata[15:8] for a word access, wdata[7:0] for a byte access.
  - BYTE1 drives mem_addr=A+1 and wdata[7:0]. A+1 wraps modulo 2^ADDR_W.
- mem_req=1 in BYTE0/BYTE1. mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and mem_ack=0.
- On mem_ack in BYTE0:
  - byte access: go to DONE.
  - word access: capture the high byte, go to BYTE1. mem_req stays high and the address advances on the next cycle.
- On mem_ack in BYTE1: capture the low byte, go to DONE.
- Timeout:
  - The counter clears on entry to BYTE0/BYTE1 and on each ack, and increments every cycle with mem_req=1 and mem_ack=0.
  - When the counter reaches ACK_TIMEOUT, set bus_err, go to DONE, and force rdata=0.
- DONE:
  - done=1 and mem_req=0.
  - rdata is the word, or the byte extended per zeroExtendFlag. rdata=0 for stores.
  - Next state is IDLE unconditionally. Request inputs seen in DONE are ignored, because the pipeline advances on this edge.
- Minimum latency: byte access 2 cycles from accept to done, word access 3 cycles, with zero-wait ack.
- bus_err clears only on rst.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- When defined, a word access with addr[0]=1 is not issued. The block goes IDLE to DONE in one cycle with mem_req never asserted, bus_err=1, done=1 and rdata=0.
- When undefined, misaligned words are performed as two byte transactions at A and A+1 with no error.

Test Plan:
- LW addr=0x0010, SRAM[0x10]=0xAB, [0x11]=0xCD, zero-wait ack -> mem_addr 0x0010 then 0x0011; done on the 3rd cycle after accept with rdata=0xABCD; stall high for exactly 3 cycles.
- LBU addr=0x0021 with [0x21]=0x9C, zeroExtendFlag=1 -> rdata=0x009C; repeat with zeroExtendFlag=0 -> rdata=0xFF9C; exactly one mem_req transaction each.
- SW addr=0x0040 wdata=0x1234, ack delayed 3 cycles per byte -> writes 0x12@0x40 then 0x34@0x41; mem_addr/mem_wdata stable during the wait; done once.
- No ack with ACK_TIMEOUT=15 on LW -> abort after 15 waiting cycles; bus_err=1, done=1, rdata=0; the next request still completes normally.
- rst asserted in BYTE1 of an SW -> mem_req low in the same cycle; all outputs at reset values; only byte 0 was written.
- memRead=memWrite=1 at 0xFFFF word (macro undefined) -> write performed at 0xFFFF then 0x0000; with DMEM_ALIGN_CHECK_EN -> no mem_req, bus_err=1, done after 1 cycle.
